// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the round datapath:
//   AES_POLY          - reduction constant for GF(2^8) modulo x^8+x^4+x^3+x+1
//   byte_t / column_t - one state byte / one 4-byte column (row 0 in the MSBs)
//   MODE_FWD/MODE_INV - MixColumns direction select values
//   state_t           - mix_columns_engine FSM encoding
//   xtime / gf_mul    - constant GF(2^8) helpers built from xtime chains
// -----------------------------------------------------------------------------
package aes_pkg;

   localparam logic [7:0] AES_POLY = 8'h1B;

   typedef logic [7:0]  byte_t;
   typedef logic [31:0] column_t;

   localparam logic MODE_FWD = 1'b0;
   localparam logic MODE_INV = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Multiply by x: shift left, fold the carried-out bit back in via AES_POLY.
   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   // Multiply by an arbitrary constant: XOR of the xtime powers selected by k.
   function automatic byte_t gf_mul(input byte_t b, input byte_t k);
      byte_t acc;
      byte_t pwr;
      acc = '0;
      pwr = b;
      for (int i = 0; i < 8; i++) begin
         if (k[i]) acc = acc ^ pwr;
         pwr = xtime(pwr);
      end
      return acc;
   endfunction

endpackage

// File: rtl/mix_single_column.sv
// -----------------------------------------------------------------------------
// mix_single_column
// Purely combinational MixColumns on one 32-bit column.
//   mode    in   MODE_FWD: matrix 02 03 01 01, MODE_INV: matrix 0E 0B 0D 09
//   col_in  in   column, row 0 in bits [31:24]
//   col_out out  transformed column, same byte order
// Every product is an XOR of x, x2, x4, x8 (repeated xtime) so no tables are
// needed and the path adds no latency.
// -----------------------------------------------------------------------------
module mix_single_column
   import aes_pkg::*;
(
   input  logic    mode,
   input  column_t col_in,
   output column_t col_out
);

   byte_t a  [4];
   byte_t x2 [4];
   byte_t x4 [4];
   byte_t x8 [4];

   for (genvar r = 0; r < 4; r++) begin : g_pow
      assign a[r]  = col_in[31-8*r -: 8];
      assign x2[r] = xtime(a[r]);
      assign x4[r] = xtime(x2[r]);
      assign x8[r] = xtime(x4[r]);
   end

   // Each matrix row is the previous one rotated right, so output row r uses
   // the coefficient sequence starting at input row r.
   for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int R1 = (r + 1) % 4;
      localparam int R2 = (r + 2) % 4;
      localparam int R3 = (r + 3) % 4;

      byte_t fwd;
      byte_t inv;

      // 02*a0 ^ 03*a1 ^ a2 ^ a3
      assign fwd = x2[r] ^ (x2[R1] ^ a[R1]) ^ a[R2] ^ a[R3];
      // 0E*a0 ^ 0B*a1 ^ 0D*a2 ^ 09*a3
      assign inv = (x8[r]  ^ x4[r]  ^ x2[r])
                 ^ (x8[R1] ^ x2[R1] ^ a[R1])
                 ^ (x8[R2] ^ x4[R2] ^ a[R2])
                 ^ (x8[R3] ^ a[R3]);

      assign col_out[31-8*r -: 8] = (mode == MODE_INV) ? inv : fwd;
   end

endmodule

// File: rtl/mix_columns_engine.sv
// -----------------------------------------------------------------------------
// mix_columns_engine
// Handshaked AES MixColumns (forward or inverse, chosen per block) working on
// COLS_PER_CYCLE columns per clock; a block takes 4/COLS_PER_CYCLE BUSY cycles.
//   CLK       in   clock, rising edge
//   RST       in   asynchronous active-high reset
//   IN_VALID  in   INPUT/MODE valid
//   IN_READY  out  a block can be accepted (0 while RST is high)
//   MODE      in   0 forward, 1 inverse; sampled only on accept
//   INPUT     in   [0:127] state, byte k = INPUT[8k:8k+7], column c = [32c:32c+31]
//   OUT_VALID out  OUTPUT holds a finished block
//   OUT_READY in   downstream takes OUTPUT
//   OUTPUT    out  [0:127] transformed state, same ordering as INPUT
//   BUSY      out  high while columns are being transformed
// -----------------------------------------------------------------------------
module mix_columns_engine
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
)
(
   input  logic         CLK,
   input  logic         RST,
   input  logic         IN_VALID,
   output logic         IN_READY,
   input  logic         MODE,
   input  logic [0:127] INPUT,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic [0:127] OUTPUT,
   output logic         BUSY
);

   localparam int NUM_GROUPS = 4 / COLS_PER_CYCLE;

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   state_t       cur_q, nxt;
   logic [1:0]   grp_q;
   logic         mode_q;
   logic [0:127] state_q, state_d;
   logic         ready_raw;
   logic         load;
   logic         last_grp;

   assign last_grp = (grp_q == 2'(NUM_GROUPS - 1));

   // ---------------------------------------------------------------------------
   // Column datapath: lane j works on column g*P + j of the state register.
   // ---------------------------------------------------------------------------
   logic [1:0] col_idx  [COLS_PER_CYCLE];
   column_t    lane_in  [COLS_PER_CYCLE];
   column_t    lane_out [COLS_PER_CYCLE];

   for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
      assign col_idx[j] = 2'(int'(grp_q) * COLS_PER_CYCLE + j);
      assign lane_in[j] = state_q[{col_idx[j], 5'd0} +: 32];

      mix_single_column u_col (
         .mode    (mode_q),
         .col_in  (lane_in[j]),
         .col_out (lane_out[j])
      );
   end

   // Columns outside the active group keep their value.
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = INPUT;
      end else if (cur_q == ST_BUSY) begin
         for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            state_d[{col_idx[j], 5'd0} +: 32] = lane_out[j];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next state and outputs
   // ---------------------------------------------------------------------------
   // NOTE: every output of this block gets a default before the case so no
   // path leaves it unassigned; otherwise a latch would be inferred.
   always_comb begin
      nxt       = cur_q;
      ready_raw = 1'b0;
      OUT_VALID = 1'b0;
      BUSY      = 1'b0;
      unique case (cur_q)
         ST_IDLE: begin
            ready_raw = 1'b1;
            if (IN_VALID) nxt = ST_BUSY;
         end
         ST_BUSY: begin
            BUSY = 1'b1;
            if (last_grp) nxt = ST_DONE;
         end
         ST_DONE: begin
            OUT_VALID = 1'b1;
            // Retiring the finished block frees the engine this same cycle.
            ready_raw = OUT_READY;
            if (OUT_READY) nxt = IN_VALID ? ST_BUSY : ST_IDLE;
         end
         default: nxt = ST_IDLE;
      endcase
   end

   // The FSM is already in IDLE during reset, so reset is masked in explicitly.
   assign IN_READY = ready_raw & ~RST;
   assign load     = IN_VALID & IN_READY;
   assign OUTPUT   = state_q;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cur_q   <= ST_IDLE;
         grp_q   <= 2'd0;
         mode_q  <= MODE_FWD;
         // NOTE: the 128-bit state register is reset, unlike a RAM array,
         // because OUTPUT must read zero as soon as RST rises.
         state_q <= '0;
      end else begin
         cur_q   <= nxt;
         state_q <= state_d;
         if (load) begin
            mode_q <= MODE;
            grp_q  <= 2'd0;
         end else if (cur_q == ST_BUSY) begin
            grp_q <= last_grp ? 2'd0 : grp_q + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_mix_columns_engine.sv
// -----------------------------------------------------------------------------
// tb_mix_columns_engine
// Three engines (COLS_PER_CYCLE = 1, 2, 4) on one clock and reset. Directed
// vector table with latency/BUSY checks on each, backpressure with
// simultaneous retire+accept, asynchronous reset mid-BUSY, then a random
// forward/inverse round trip per engine against a long-multiplication model.
// -----------------------------------------------------------------------------
module tb_mix_columns_engine;

   localparam int NRAND = 1000;

   logic                 clk;
   logic                 rst;
   logic [2:0]           in_valid;
   logic [2:0]           in_ready;
   logic [2:0]           mode;
   logic [2:0]           out_valid;
   logic [2:0]           out_ready;
   logic [2:0]           busy;
   logic [2:0][0:127]    din;
   logic [2:0][0:127]    dout;

   int checks   = 0;
   int failures = 0;

   logic [0:127] exp_q [3][$];

   typedef struct {
      logic         mode;
      logic [0:127] din;
      logic [0:127] dout;
   } vec_t;

   vec_t vecs [6];

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      mix_columns_engine #(
         .COLS_PER_CYCLE ((gi == 0) ? 1 : (gi == 1) ? 2 : 4)
      ) u_dut (
         .CLK       (clk),
         .RST       (rst),
         .IN_VALID  (in_valid[gi]),
         .IN_READY  (in_ready[gi]),
         .MODE      (mode[gi]),
         .INPUT     (din[gi]),
         .OUT_VALID (out_valid[gi]),
         .OUT_READY (out_ready[gi]),
         .OUTPUT    (dout[gi]),
         .BUSY      (busy[gi])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation still running, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   // --------------------------------------------------------------------------
   // Helpers
   // --------------------------------------------------------------------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   function automatic int p_of(input int i);
      return (i == 0) ? 1 : (i == 1) ? 2 : 4;
   endfunction

   // Reference GF(2^8) multiply: carry-less product then polynomial reduction.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (16'(a) << k);
      for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011B << (k - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] coef(input logic inv, input int d);
      case (d)
         0:       return inv ? 8'h0E : 8'h02;
         1:       return inv ? 8'h0B : 8'h03;
         2:       return inv ? 8'h0D : 8'h01;
         default: return inv ? 8'h09 : 8'h01;
      endcase
   endfunction

   function automatic logic [0:127] model_mix(input logic [0:127] blk, input logic inv);
      logic [0:127] res;
      logic [7:0]   acc;
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(coef(inv, (j - r) & 3), blk[32*c + 8*j +: 8]);
            res[32*c + 8*r +: 8] = acc;
         end
      end
      return res;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input int i, input logic m, input logic [0:127] blk);
      int n;
      n = 0;
      in_valid[i] = 1'b1;
      mode[i]     = m;
      din[i]      = blk;
      #1;
      while (!in_ready[i] && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check($sformatf("p%0d_accept_ready", p_of(i)), 128'(in_ready[i]), 128'(1));
      @(negedge clk);
      in_valid[i] = 1'b0;
      din[i]      = ~blk;
   endtask

   // Counts cycles from the first BUSY cycle until OUT_VALID, optionally
   // toggling MODE every cycle to show it is ignored after accept.
   task automatic wait_done(input int i, input bit toggle, output int lat, output int bc);
      lat = 1;
      bc  = 0;
      while (lat < 20) begin
         #1;
         if (out_valid[i]) break;
         if (busy[i]) bc++;
         if (toggle) mode[i] = ~mode[i];
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic retire(input int i);
      out_ready[i] = 1'b1;
      @(negedge clk);
      out_ready[i] = 1'b0;
      #1;
      check($sformatf("p%0d_retire_vr", p_of(i)), 128'({out_valid[i], in_ready[i]}), 128'(2'b01));
      @(negedge clk);
   endtask

   task automatic run_vec(input int i, input int vi, input vec_t v, input bit toggle);
      int lat, bc;
      send(i, v.mode, v.din);
      wait_done(i, toggle, lat, bc);
      check($sformatf("p%0d_v%0d_latency", p_of(i), vi), 128'(lat), 128'(4 / p_of(i) + 1));
      check($sformatf("p%0d_v%0d_busy_cycles", p_of(i), vi), 128'(bc), 128'(4 / p_of(i)));
      check($sformatf("p%0d_v%0d_data", p_of(i), vi), dout[i], v.dout);
      retire(i);
   endtask

   task automatic drive_one(input int i, input logic m, input logic [0:127] blk,
                            input logic [0:127] expv, output bit ok);
      int n;
      n  = 0;
      ok = 1'b1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      in_valid[i] = 1'b1;
      mode[i]     = m;
      din[i]      = blk;
      #1;
      while (!in_ready[i] && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ready[i]) begin
         check($sformatf("p%0d_rand_accept_timeout", p_of(i)), 128'(in_ready[i]), 128'(1));
         ok = 1'b0;
      end else begin
         exp_q[i].push_back(expv);
      end
      @(negedge clk);
      in_valid[i] = 1'b0;
      mode[i]     = 1'($urandom);
      din[i]      = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic rand_drive(input int i);
      logic [0:127] x, y;
      bit ok;
      for (int b = 0; b < NRAND; b++) begin
         x = {$urandom, $urandom, $urandom, $urandom};
         y = model_mix(x, 1'b0);
         drive_one(i, 1'b0, x, y, ok);
         if (!ok) break;
         drive_one(i, 1'b1, y, x, ok);
         if (!ok) break;
      end
   endtask

   task automatic rand_mon(input int i);
      int got, cyc;
      bit extra;
      got = 0;
      cyc = 0;
      while (got < 2 * NRAND && cyc < 40000) begin
         out_ready[i] = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid[i] && out_ready[i]) begin
            if (exp_q[i].size() == 0)
               check($sformatf("p%0d_rand_unexpected_block", p_of(i)), 128'(1), 128'(0));
            else
               check($sformatf("p%0d_rand_block%0d", p_of(i), got), dout[i], exp_q[i].pop_front());
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      out_ready[i] = 1'b0;
      check($sformatf("p%0d_rand_count", p_of(i)), 128'(got), 128'(2 * NRAND));
      extra = 1'b0;
      repeat (10) begin
         #1;
         extra = extra | out_valid[i];
         @(negedge clk);
      end
      check($sformatf("p%0d_rand_no_duplicate", p_of(i)), 128'(extra), 128'(0));
      check($sformatf("p%0d_rand_queue_empty", p_of(i)), 128'(exp_q[i].size()), 128'(0));
   endtask

   // --------------------------------------------------------------------------
   // Test sequence
   // --------------------------------------------------------------------------
   initial begin
      int  lat, bc;
      bit  spurious;

      vecs[0] = '{1'b0, 128'hdb135345_f20a225c_01010101_2d26314c, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8};
      vecs[1] = '{1'b1, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 128'hdb135345_f20a225c_01010101_2d26314c};
      vecs[2] = '{1'b0, 128'hc6c6c6c6_d4d4d4d5_01010101_c6c6c6c6, 128'hc6c6c6c6_d5d5d7d6_01010101_c6c6c6c6};
      vecs[3] = '{1'b1, 128'hc6c6c6c6_d5d5d7d6_01010101_c6c6c6c6, 128'hc6c6c6c6_d4d4d4d5_01010101_c6c6c6c6};
      vecs[4] = '{1'b0, 128'h01000000_80000000_ffffffff_00000000, 128'h02010103_1b80809b_ffffffff_00000000};
      vecs[5] = '{1'b1, 128'h01000000_80000000_ffffffff_00000000, 128'h0e090d0b_41ecdaf7_ffffffff_00000000};

      rst       = 1'b1;
      in_valid  = '0;
      mode      = '0;
      out_ready = '0;
      din       = '0;

      // Reset state
      #3;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("p%0d_reset_flags", p_of(i)),
               128'({in_ready[i], out_valid[i], busy[i]}), 128'(3'b000));
         check($sformatf("p%0d_reset_output", p_of(i)), dout[i], 128'h0);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++)
         check($sformatf("p%0d_idle_ready", p_of(i)), 128'(in_ready[i]), 128'(1));
      @(negedge clk);

      // Directed table, every engine; inverse vectors toggle MODE during BUSY
      for (int i = 0; i < 3; i++)
         for (int v = 0; v < 6; v++)
            run_vec(i, v, vecs[v], vecs[v].mode);

      // Backpressure on P=1, then simultaneous retire + accept
      send(0, vecs[0].mode, vecs[0].din);
      wait_done(0, 1'b0, lat, bc);
      check("bp_first_latency", 128'(lat), 128'(5));
      for (int k = 0; k < 10; k++) begin
         check($sformatf("bp_hold%0d_flags", k), 128'({out_valid[0], in_ready[0]}), 128'(2'b10));
         check($sformatf("bp_hold%0d_data", k), dout[0], vecs[0].dout);
         @(negedge clk);
         if (k >= 3) begin
            in_valid[0] = 1'b1;
            mode[0]     = vecs[2].mode;
            din[0]      = vecs[2].din;
         end
         #1;
      end
      out_ready[0] = 1'b1;
      #1;
      check("bp_passthrough_ready", 128'(in_ready[0]), 128'(1));
      @(negedge clk);
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b0;
      din[0]       = '1;
      wait_done(0, 1'b0, lat, bc);
      check("bp_second_latency", 128'(lat), 128'(5));
      check("bp_second_busy_cycles", 128'(bc), 128'(4));
      check("bp_second_data", dout[0], vecs[2].dout);
      retire(0);

      // Asynchronous reset in the second BUSY cycle
      send(0, vecs[0].mode, vecs[0].din);
      @(negedge clk);
      #1;
      check("rst_mid_busy_before", 128'(busy[0]), 128'(1));
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_busy_flags", 128'({out_valid[0], busy[0], in_ready[0]}), 128'(3'b000));
      check("rst_mid_busy_output", dout[0], 128'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_release_ready", 128'(in_ready[0]), 128'(1));
      spurious = 1'b0;
      repeat (12) begin
         @(negedge clk);
         #1;
         spurious = spurious | out_valid[0];
      end
      check("rst_no_spurious_valid", 128'(spurious), 128'(0));
      @(negedge clk);
      run_vec(0, 0, vecs[0], 1'b0);

      // Random round trip, all engines concurrently
      for (int i = 0; i < 3; i++) begin
         automatic int ii = i;
         fork
            rand_drive(ii);
            rand_mon(ii);
         join_none
      end
      wait fork;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
